// File: rtl/writeback_buffer.sv
// writeback_buffer: collects results from ALU0, ALU1 and LSU through a shared
// valid/ready handshake, queues them in a DEPTH-entry FIFO and drains up to two
// per cycle onto the register file write ports, oldest entry on port 0.
// Optional feature macro: WB_ZERO_REG_FILTER_EN (drop results aimed at p0).
module writeback_buffer #(
  parameter int NUM_P_REGS = 64,
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2:0]                    in_valid_i,
  output logic                          in_ready_o,
  input  logic [$clog2(NUM_P_REGS)-1:0] in_dest0_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] in_dest1_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] in_dest2_i,
  input  logic [WORD_SIZE-1:0]          in_word0_i,
  input  logic [WORD_SIZE-1:0]          in_word1_i,
  input  logic [WORD_SIZE-1:0]          in_word2_i,
  output logic                          reg_write0_o,
  output logic                          reg_write1_o,
  output logic [$clog2(NUM_P_REGS)-1:0] dest0_o,
  output logic [$clog2(NUM_P_REGS)-1:0] dest1_o,
  output logic [WORD_SIZE-1:0]          word0_o,
  output logic [WORD_SIZE-1:0]          word1_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          full_o
);

  localparam int TAG_W = $clog2(NUM_P_REGS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_PUSH = CNT_W'(3);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [TAG_W-1:0]     dest_mem [DEPTH];
  logic [WORD_SIZE-1:0] word_mem [DEPTH];

  logic [TAG_W-1:0]     ch_dest [3];
  logic [WORD_SIZE-1:0] ch_word [3];

  logic [2:0]       accept;
  logic [1:0]       slot_off [3];
  logic [1:0]       pushes;
  logic [1:0]       pops;
  logic [CNT_W-1:0] free_slots;
  logic [PTR_W-1:0] head_next1;

  assign ch_dest[0] = in_dest0_i;
  assign ch_dest[1] = in_dest1_i;
  assign ch_dest[2] = in_dest2_i;
  assign ch_word[0] = in_word0_i;
  assign ch_word[1] = in_word1_i;
  assign ch_word[2] = in_word2_i;

  // Ready depends only on registered occupancy: room for a worst-case triple push.
  always_comb begin
    free_slots = DEPTH_C - count;
    in_ready_o = !rst_i && (free_slots >= MAX_PUSH);
  end

  // Decide which channels enqueue and pack them into consecutive slots in channel order.
  always_comb begin
    accept = 3'b000;
    for (int k = 0; k < 3; k++) begin
`ifdef WB_ZERO_REG_FILTER_EN
      accept[k] = in_valid_i[k] && in_ready_o && (ch_dest[k] != '0);
`else
      accept[k] = in_valid_i[k] && in_ready_o;
`endif
    end
    slot_off[0] = 2'd0;
    slot_off[1] = 2'(accept[0]);
    slot_off[2] = 2'(accept[0]) + 2'(accept[1]);
    pushes      = slot_off[2] + 2'(accept[2]);
  end

  // Every occupied head entry is committed this cycle, at most two.
  always_comb begin
    pops = 2'd0;
    if (count >= CNT_W'(2)) begin
      pops = 2'd2;
    end else if (count == CNT_W'(1)) begin
      pops = 2'd1;
    end
  end

  // Storage is left unreset; stale slots are never visible because outputs are gated by count.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++) begin
      if (accept[k]) begin
        dest_mem[tail + PTR_W'(slot_off[k])] <= ch_dest[k];
        word_mem[tail + PTR_W'(slot_off[k])] <= ch_word[k];
      end
    end
  end

  // Pointer and occupancy registers; reset discards every queued entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pops);
      tail  <= tail + PTR_W'(pushes);
      count <= count + CNT_W'(pushes) - CNT_W'(pops);
    end
  end

  // Drive the two write ports from the head pair; pointer arithmetic wraps at DEPTH.
  always_comb begin
    head_next1   = head + PTR_W'(1);
    reg_write0_o = 1'b0;
    reg_write1_o = 1'b0;
    dest0_o      = '0;
    dest1_o      = '0;
    word0_o      = '0;
    word1_o      = '0;
    if (count >= CNT_W'(1)) begin
      reg_write0_o = 1'b1;
      dest0_o      = dest_mem[head];
      word0_o      = word_mem[head];
    end
    if (count >= CNT_W'(2)) begin
      reg_write1_o = 1'b1;
      dest1_o      = dest_mem[head_next1];
      word1_o      = word_mem[head_next1];
    end
  end

  assign count_o = count;
  assign full_o  = (count == DEPTH_C);

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed vector table, reset/filter sequences and a
// scoreboard-checked random stream for writeback_buffer.
module tb_writeback_buffer;

  localparam int DEPTH = 8;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  in_valid_i;
  logic        in_ready_o;
  logic [5:0]  in_dest0_i, in_dest1_i, in_dest2_i;
  logic [31:0] in_word0_i, in_word1_i, in_word2_i;
  logic        reg_write0_o, reg_write1_o;
  logic [5:0]  dest0_o, dest1_o;
  logic [31:0] word0_o, word1_o;
  logic [3:0]  count_o;
  logic        full_o;

  int assertions = 0;
  int failures   = 0;
  int writes_in_reset = 0;
  logic [31:0] rf [64];

  writeback_buffer #(.NUM_P_REGS(64), .WORD_SIZE(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_dest0_i(in_dest0_i), .in_dest1_i(in_dest1_i), .in_dest2_i(in_dest2_i),
    .in_word0_i(in_word0_i), .in_word1_i(in_word1_i), .in_word2_i(in_word2_i),
    .reg_write0_o(reg_write0_o), .reg_write1_o(reg_write1_o),
    .dest0_o(dest0_o), .dest1_o(dest1_o), .word0_o(word0_o), .word1_o(word1_o),
    .count_o(count_o), .full_o(full_o)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [5:0]  d0, d1, d2;
    logic [31:0] w0, w1, w2;
    logic        erw0;
    logic [5:0]  ed0;
    logic [31:0] ew0;
    logic        erw1;
    logic [5:0]  ed1;
    logic [31:0] ew1;
    logic [3:0]  ecount;
    logic        eready;
  } vec_t;

  vec_t vecs [13];

  // Free-running clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Register file model: port 1 lands after port 0; also flags writes under reset.
  always @(posedge clk_i) begin
    if (rst_i && (reg_write0_o || reg_write1_o)) writes_in_reset++;
    if (reg_write0_o) rf[dest0_o] <= word0_o;
    if (reg_write1_o) rf[dest1_o] <= word1_o;
  end

  task automatic applyStimulus(input logic [2:0] v,
                               input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                               input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    in_valid_i = v;
    in_dest0_i = a; in_dest1_i = b; in_dest2_i = c;
    in_word0_i = x; in_word1_i = y; in_word2_i = z;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [5:0]  q_dest [$];
    logic [31:0] q_word [$];
    logic [2:0]  pv;
    logic [5:0]  pd [3];
    logic [31:0] pw [3];
    int generated;
    int cycles;
    int npop;
    logic exp_ready;

    //           valid   d0     d1     d2     w0            w1     w2     rw0   ed0    ew0            rw1   ed1    ew1       cnt    rdy
    vecs[0]  = '{3'b000, 6'd0,  6'd0,  6'd0,  32'h0,        32'h0, 32'h0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    4'd0, 1'b1};
    vecs[1]  = '{3'b010, 6'd0,  6'd5,  6'd0,  32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,    4'd1, 1'b1};
    vecs[2]  = '{3'b000, 6'd0,  6'd0,  6'd0,  32'h0,        32'h0, 32'h0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    4'd0, 1'b1};
    vecs[3]  = '{3'b111, 6'd7,  6'd7,  6'd7,  32'h1,        32'h2, 32'h3, 1'b1, 6'd7,  32'h1,        1'b1, 6'd7,  32'h2,    4'd3, 1'b1};
    vecs[4]  = '{3'b000, 6'd0,  6'd0,  6'd0,  32'h0,        32'h0, 32'h0, 1'b1, 6'd7,  32'h3,        1'b0, 6'd0,  32'h0,    4'd1, 1'b1};
    vecs[5]  = '{3'b000, 6'd0,  6'd0,  6'd0,  32'h0,        32'h0, 32'h0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    4'd0, 1'b1};
    vecs[6]  = '{3'b101, 6'd10, 6'd0,  6'd11, 32'hA,        32'h0, 32'hB, 1'b1, 6'd10, 32'hA,        1'b1, 6'd11, 32'hB,    4'd2, 1'b1};
    vecs[7]  = '{3'b011, 6'd12, 6'd13, 6'd0,  32'hC,        32'hD, 32'h0, 1'b1, 6'd12, 32'hC,        1'b1, 6'd13, 32'hD,    4'd2, 1'b1};
    vecs[8]  = '{3'b100, 6'd0,  6'd0,  6'd14, 32'h0,        32'h0, 32'hE, 1'b1, 6'd14, 32'hE,        1'b0, 6'd0,  32'h0,    4'd1, 1'b1};
    vecs[9]  = '{3'b000, 6'd0,  6'd0,  6'd0,  32'h0,        32'h0, 32'h0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    4'd0, 1'b1};
    vecs[10] = '{3'b111, 6'd20, 6'd21, 6'd22, 32'h20,      32'h21, 32'h22, 1'b1, 6'd20, 32'h20,       1'b1, 6'd21, 32'h21,   4'd3, 1'b1};
    vecs[11] = '{3'b111, 6'd23, 6'd24, 6'd25, 32'h23,      32'h24, 32'h25, 1'b1, 6'd22, 32'h22,       1'b1, 6'd23, 32'h23,   4'd4, 1'b1};
    vecs[12] = '{3'b111, 6'd26, 6'd27, 6'd28, 32'h26,      32'h27, 32'h28, 1'b1, 6'd24, 32'h24,       1'b1, 6'd25, 32'h25,   4'd5, 1'b1};

    for (int r = 0; r < 64; r++) rf[r] = 32'h0;
    rst_i = 1'b1;
    idle();
    #12;
    checkOutput("rst_ready", 64'(in_ready_o), 64'(1'b0));
    checkOutput("rst_count", 64'(count_o), 64'(4'd0));
    checkOutput("rst_full", 64'(full_o), 64'(1'b0));
    checkOutput("rst_rw0", 64'(reg_write0_o), 64'(1'b0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("idle_ready", 64'(in_ready_o), 64'(1'b1));

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                    vecs[i].w0, vecs[i].w1, vecs[i].w2);
      @(posedge clk_i); #1;
      idle();
      checkOutput($sformatf("v%0d_rw0", i), 64'(reg_write0_o), 64'(vecs[i].erw0));
      checkOutput($sformatf("v%0d_dest0", i), 64'(dest0_o), 64'(vecs[i].ed0));
      checkOutput($sformatf("v%0d_word0", i), 64'(word0_o), 64'(vecs[i].ew0));
      checkOutput($sformatf("v%0d_rw1", i), 64'(reg_write1_o), 64'(vecs[i].erw1));
      checkOutput($sformatf("v%0d_dest1", i), 64'(dest1_o), 64'(vecs[i].ed1));
      checkOutput($sformatf("v%0d_word1", i), 64'(word1_o), 64'(vecs[i].ew1));
      checkOutput($sformatf("v%0d_count", i), 64'(count_o), 64'(vecs[i].ecount));
      checkOutput($sformatf("v%0d_ready", i), 64'(in_ready_o), 64'(vecs[i].eready));
      checkOutput($sformatf("v%0d_full", i), 64'(full_o), 64'(1'b0));
    end
    checkOutput("rf_reg7", 64'(rf[7]), 64'(32'h3));

    // Asynchronous reset with five entries queued, mid-cycle.
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_count", 64'(count_o), 64'(4'd0));
    checkOutput("arst_rw0", 64'(reg_write0_o), 64'(1'b0));
    checkOutput("arst_rw1", 64'(reg_write1_o), 64'(1'b0));
    checkOutput("arst_dest0", 64'(dest0_o), 64'(6'd0));
    checkOutput("arst_ready", 64'(in_ready_o), 64'(1'b0));
    @(posedge clk_i); #1;
    checkOutput("arst_held_rw0", 64'(reg_write0_o), 64'(1'b0));
    checkOutput("arst_no_writes", 64'(writes_in_reset), 64'(0));
    #2;
    rst_i = 1'b0;
    applyStimulus(3'b001, 6'd9, 6'd0, 6'd0, 32'h99, 32'h0, 32'h0);
    @(posedge clk_i); #1;
    idle();
    checkOutput("post_rst_rw0", 64'(reg_write0_o), 64'(1'b1));
    checkOutput("post_rst_dest0", 64'(dest0_o), 64'(6'd9));
    checkOutput("post_rst_word0", 64'(word0_o), 64'(32'h99));
    checkOutput("post_rst_rw1", 64'(reg_write1_o), 64'(1'b0));
    checkOutput("post_rst_count", 64'(count_o), 64'(4'd1));
    @(posedge clk_i); #1;

    // Destination-zero handling on a triple push.
    applyStimulus(3'b111, 6'd0, 6'd4, 6'd0, 32'h50, 32'h44, 32'h52);
    @(posedge clk_i); #1;
    idle();
`ifdef WB_ZERO_REG_FILTER_EN
    checkOutput("zf_count", 64'(count_o), 64'(4'd1));
    checkOutput("zf_dest0", 64'(dest0_o), 64'(6'd4));
    checkOutput("zf_word0", 64'(word0_o), 64'(32'h44));
    checkOutput("zf_rw1", 64'(reg_write1_o), 64'(1'b0));
`else
    checkOutput("z_count", 64'(count_o), 64'(4'd3));
    checkOutput("z_dest0", 64'(dest0_o), 64'(6'd0));
    checkOutput("z_word0", 64'(word0_o), 64'(32'h50));
    checkOutput("z_dest1", 64'(dest1_o), 64'(6'd4));
    checkOutput("z_word1", 64'(word1_o), 64'(32'h44));
`endif
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("drained_count", 64'(count_o), 64'(4'd0));

    // Saturating burst followed by a random stream, both against a scoreboard.
    generated = 0;
    cycles    = 0;
    pv = 3'b000;
    for (int k = 0; k < 3; k++) begin
      pd[k] = 6'd0;
      pw[k] = 32'h0;
    end
    while ((generated < 64 || pv != 3'b000 || q_dest.size() != 0) && cycles < 1000) begin
      cycles++;
      for (int k = 0; k < 3; k++) begin
        if (!pv[k] && generated < 64) begin
          pv[k] = (generated < 24) ? 1'b1 : 1'($urandom_range(0, 1));
          if (pv[k]) begin
            pd[k] = 6'($urandom_range(0, 63));
            pw[k] = $urandom;
            generated++;
          end
        end
      end
      applyStimulus(pv, pd[0], pd[1], pd[2], pw[0], pw[1], pw[2]);
      #3;
      exp_ready = (DEPTH - q_dest.size()) >= 3;
      checkOutput("sb_count", 64'(count_o), 64'(q_dest.size()));
      checkOutput("sb_ready", 64'(in_ready_o), 64'(exp_ready));
      checkOutput("sb_full", 64'(full_o), 64'(q_dest.size() == DEPTH));
      checkOutput("sb_rw0", 64'(reg_write0_o), 64'(q_dest.size() >= 1));
      checkOutput("sb_rw1", 64'(reg_write1_o), 64'(q_dest.size() >= 2));
      if (q_dest.size() >= 1) begin
        checkOutput("sb_dest0", 64'(dest0_o), 64'(q_dest[0]));
        checkOutput("sb_word0", 64'(word0_o), 64'(q_word[0]));
      end
      if (q_dest.size() >= 2) begin
        checkOutput("sb_dest1", 64'(dest1_o), 64'(q_dest[1]));
        checkOutput("sb_word1", 64'(word1_o), 64'(q_word[1]));
      end
      npop = (q_dest.size() >= 2) ? 2 : q_dest.size();
      for (int p = 0; p < npop; p++) begin
        void'(q_dest.pop_front());
        void'(q_word.pop_front());
      end
      if (exp_ready) begin
        for (int k = 0; k < 3; k++) begin
          if (pv[k]) begin
`ifdef WB_ZERO_REG_FILTER_EN
            if (pd[k] != 6'd0) begin
              q_dest.push_back(pd[k]);
              q_word.push_back(pw[k]);
            end
`else
            q_dest.push_back(pd[k]);
            q_word.push_back(pw[k]);
`endif
            pv[k] = 1'b0;
          end
        end
      end
      @(posedge clk_i); #1;
    end
    idle();
    checkOutput("sb_all_drained", 64'(q_dest.size() + 32'(pv != 3'b000)), 64'(0));
    checkOutput("sb_final_count", 64'(count_o), 64'(4'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
